strip_scan_ctrl: RTL and testbench

- Sequencer for the 3x3-window strip memory, which has a `wr` write port, an `rd` read port and a synchronous clear via its `rst_n`.
- Per strip: clears the memory pointers, then loads one padded strip through a valid/ready pixel stream, then scans every output window with `rd`.
- Emits window-valid/last strobes aligned to the memory's 1-cycle read latency; repeats for all strips of a frame.
- Sits between the padded-pixel source and the 3x3 filter datapath.

---
 rtl/strip_scan_pkg.sv | 33 +++
 rtl/strip_scan_ctrl_xy.sv | 55 +++++
 rtl/strip_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_strip_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/strip_scan_pkg.sv
// Shared types, default dimensions and sizing helpers for the strip scan sequencer.
package strip_scan_pkg;

  localparam int DEF_IMG_W      = 256;
  localparam int DEF_STRIP_ROWS = 32;
  localparam int DEF_N_STRIPS   = 8;
  localparam int DEF_PIX_W      = 8;

  localparam int ROW_PITCH = DEF_IMG_W + 2;
  localparam int LOAD_N    = ROW_PITCH * (DEF_STRIP_ROWS + 2);
  localparam int SCAN_N    = DEF_IMG_W * DEF_STRIP_ROWS;

  typedef logic [DEF_PIX_W-1:0] pix_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    SCAN,
    DRAIN,
    DONE
  } state_e;

  function automatic int load_n(input int img_w, input int strip_rows);
    return (img_w + 2) * (strip_rows + 2);
  endfunction

  // Counter width that never collapses to zero bits for a count of one.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/strip_scan_ctrl_xy.sv
// Column/row raster counter with clear, enable and a terminal flag on the last position.
module scan_xy_counter
  import strip_scan_pkg::*;
#(
  parameter int COLS = DEF_IMG_W,
  parameter int ROWS = DEF_STRIP_ROWS,
  localparam int CW  = cw(COLS),
  localparam int RW  = cw(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/strip_scan_ctrl.sv
// Strip memory sequencer: clear, load one padded strip, scan all windows, repeat per strip.
// Optional STRIP_SCAN_COORD_EN adds win_x/win_y frame coordinates of each window.
module strip_scan_ctrl
  import strip_scan_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int STRIP_ROWS = DEF_STRIP_ROWS,
  parameter int N_STRIPS   = DEF_N_STRIPS,
  parameter int PIX_W      = DEF_PIX_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [PIX_W-1:0]          pix_in,
  input  logic                      pix_in_valid,
  output logic                      pix_in_ready,
  input  logic                      win_ready,
  output logic                      mem_clr_n,
  output logic                      mem_wr,
  output logic [PIX_W-1:0]          mem_pixelw,
  output logic                      mem_rd,
  output logic                      win_valid,
  output logic                      win_last,
  output logic [cw(N_STRIPS)-1:0]   strip_idx,
  output logic                      busy,
  output logic                      done
`ifdef STRIP_SCAN_COORD_EN
  ,
  output logic [cw(IMG_W)-1:0]                 win_x,
  output logic [cw(STRIP_ROWS*N_STRIPS)-1:0]   win_y
`endif
);

  localparam int LOAD_TOTAL = load_n(IMG_W, STRIP_ROWS);
  localparam int LOAD_W     = $clog2(LOAD_TOTAL + 1);
  localparam int COL_W      = cw(IMG_W);
  localparam int ROW_W      = cw(STRIP_ROWS);
  localparam int STRIP_W    = cw(N_STRIPS);
  localparam logic [LOAD_W-1:0]  LOAD_LAST  = LOAD_W'(LOAD_TOTAL - 1);
  localparam logic [STRIP_W-1:0] STRIP_LAST = STRIP_W'(N_STRIPS - 1);

  state_e               state_q, state_d;
  logic [LOAD_W-1:0]    load_cnt_q, load_cnt_d;
  logic [STRIP_W-1:0]   strip_q, strip_d;
  logic                 clr_n_q, clr_n_d;
  logic                 ready_q, ready_d;
  logic                 scan_q, scan_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wv_q, wv_d;
  logic                 wl_q, wl_d;

  logic                 fire, rd, xy_last;
  logic [COL_W-1:0]     xy_col;
  logic [ROW_W-1:0]     xy_row;

  assign fire = ready_q & pix_in_valid;
  // Reads follow win_ready directly so a downstream stall freezes the memory in place.
  assign rd   = scan_q & win_ready;

  scan_xy_counter #(
    .COLS (IMG_W),
    .ROWS (STRIP_ROWS)
  ) u_xy (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == CLEAR),
    .en    (rd),
    .col   (xy_col),
    .row   (xy_row),
    .last  (xy_last)
  );

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    strip_d    = strip_q;
    wv_d       = rd;
    wl_d       = rd & xy_last;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLEAR;
        strip_d = '0;
      end
      CLEAR: begin
        load_cnt_d = '0;
        state_d    = LOAD;
      end
      LOAD: if (fire) begin
        load_cnt_d = load_cnt_q + 1'b1;
        if (load_cnt_q == LOAD_LAST) state_d = SCAN;
      end
      SCAN: if (rd && xy_last) state_d = DRAIN;
      DRAIN: if (strip_q != STRIP_LAST) begin
        strip_d = strip_q + 1'b1;
        state_d = CLEAR;
      end else begin
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    clr_n_d = state_d inside {LOAD, SCAN, DRAIN};
    ready_d = (state_d == LOAD);
    scan_d  = (state_d == SCAN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      strip_q    <= '0;
      clr_n_q    <= 1'b0;
      ready_q    <= 1'b0;
      scan_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wv_q       <= 1'b0;
      wl_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      strip_q    <= strip_d;
      clr_n_q    <= clr_n_d;
      ready_q    <= ready_d;
      scan_q     <= scan_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wv_q       <= wv_d;
      wl_q       <= wl_d;
    end
  end

  assign pix_in_ready = ready_q;
  assign mem_clr_n    = clr_n_q;
  assign mem_wr       = fire;
  assign mem_pixelw   = pix_in;
  assign mem_rd       = rd;
  assign win_valid    = wv_q;
  assign win_last     = wl_q;
  assign strip_idx    = strip_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef STRIP_SCAN_COORD_EN
  localparam int Y_W = cw(STRIP_ROWS * N_STRIPS);

  logic [COL_W-1:0] win_x_q, win_x_d;
  logic [Y_W-1:0]   win_y_q, win_y_d;

  always_comb begin
    win_x_d = win_x_q;
    win_y_d = win_y_q;
    if (rd) begin
      win_x_d = xy_col;
      win_y_d = Y_W'(int'(strip_q) * STRIP_ROWS + int'(xy_row));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_x_q <= '0;
      win_y_q <= '0;
    end else begin
      win_x_q <= win_x_d;
      win_y_q <= win_y_d;
    end
  end

  assign win_x = win_x_q;
  assign win_y = win_y_q;
`else
  logic unused_xy;
  assign unused_xy = ^{xy_col, xy_row};
`endif

endmodule

// File: tb/tb_strip_scan_ctrl.sv
// Directed bench for strip_scan_ctrl on a reduced 8x4 strip geometry, 4 strips per frame.
module tb_strip_scan_ctrl;

  localparam int IMG_W  = 8;
  localparam int SR     = 4;
  localparam int NS     = 4;
  localparam int PW     = 8;
  localparam int LOAD_N = 60;   // (8+2)*(4+2)
  localparam int SCAN_N = 32;   // 8*4
  localparam int LIMIT  = 5000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [PW-1:0] pix_in;
  logic          pix_in_valid;
  logic          pix_in_ready;
  logic          win_ready;
  logic          mem_clr_n;
  logic          mem_wr;
  logic [PW-1:0] mem_pixelw;
  logic          mem_rd;
  logic          win_valid;
  logic          win_last;
  logic [1:0]    strip_idx;
  logic          busy;
  logic          done;
`ifdef STRIP_SCAN_COORD_EN
  logic [2:0]    win_x;
  logic [3:0]    win_y;
`endif

  strip_scan_ctrl #(
    .IMG_W(IMG_W), .STRIP_ROWS(SR), .N_STRIPS(NS), .PIX_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
    .win_ready(win_ready), .mem_clr_n(mem_clr_n), .mem_wr(mem_wr),
    .mem_pixelw(mem_pixelw), .mem_rd(mem_rd), .win_valid(win_valid),
    .win_last(win_last), .strip_idx(strip_idx), .busy(busy), .done(done)
`ifdef STRIP_SCAN_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observers, sampled on the falling edge.
  int n_wr = 0, n_rd = 0, n_wv = 0, n_wl = 0, n_done = 0, n_loads = 0;
  int e_wr_novalid = 0, e_data = 0, e_overlap = 0, e_rd_early = 0;
  int e_last = 0, e_sidx = 0, e_coord = 0;
  int strip_wr = 0, strip_rd = 0, strip_wv = 0, frame_lasts = 0;
  logic clr_prev = 1'b0;
  int wv_new;

  always_comb wv_new = mem_clr_n ? strip_wv + (win_valid ? 1 : 0) : 0;

  always @(negedge clk) begin
    n_wr    <= n_wr + (mem_wr ? 1 : 0);
    n_rd    <= n_rd + (mem_rd ? 1 : 0);
    n_wv    <= n_wv + (win_valid ? 1 : 0);
    n_wl    <= n_wl + (win_last ? 1 : 0);
    n_done  <= n_done + (done ? 1 : 0);
    n_loads <= n_loads + ((mem_clr_n && !clr_prev) ? 1 : 0);
    clr_prev <= mem_clr_n;
    if (mem_wr && !pix_in_valid) e_wr_novalid <= e_wr_novalid + 1;
    if (mem_wr && mem_pixelw !== pix_in) e_data <= e_data + 1;
    if (mem_wr && mem_rd) e_overlap <= e_overlap + 1;
    if (mem_rd && strip_wr != LOAD_N) e_rd_early <= e_rd_early + 1;
    if (win_last && (!win_valid || wv_new != SCAN_N)) e_last <= e_last + 1;
    if (win_last && strip_idx != 2'(frame_lasts)) e_sidx <= e_sidx + 1;
`ifdef STRIP_SCAN_COORD_EN
    if (win_valid && (win_x != 3'((wv_new - 1) % IMG_W) ||
                      win_y != 4'(frame_lasts * SR + (wv_new - 1) / IMG_W)))
      e_coord <= e_coord + 1;
`endif
    strip_wr    <= mem_clr_n ? strip_wr + (mem_wr ? 1 : 0) : 0;
    strip_rd    <= mem_clr_n ? strip_rd + (mem_rd ? 1 : 0) : 0;
    strip_wv    <= wv_new;
    frame_lasts <= !busy ? 0 : frame_lasts + (win_last ? 1 : 0);
  end

  bit toggle_mode = 1'b0;
  int b_wr, b_rd, b_wv, b_wl, b_done, b_loads;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pix_in = PW'($urandom);
    if (toggle_mode) pix_in_valid = ~pix_in_valid;
    else             pix_in_valid = 1'b1;
  endtask

  task automatic snap();
    b_wr = n_wr; b_rd = n_rd; b_wv = n_wv; b_wl = n_wl; b_done = n_done; b_loads = n_loads;
  endtask

  task automatic wait_done(inout int cyc);
    while (!done && cyc < LIMIT) begin
      tick();
      cyc++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic frame_totals(input string tag);
    tick();
    check({tag, "_wr"},    n_wr - b_wr, NS * LOAD_N);
    check({tag, "_rd"},    n_rd - b_rd, NS * SCAN_N);
    check({tag, "_wv"},    n_wv - b_wv, NS * SCAN_N);
    check({tag, "_last"},  n_wl - b_wl, NS);
    check({tag, "_loads"}, n_loads - b_loads, NS);
    check({tag, "_done"},  n_done - b_done, 1);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int cyc;
    int stall_rd, stall_wv;
    rst_n = 1'b0; start = 1'b0; pix_in = '0; pix_in_valid = 1'b0; win_ready = 1'b1;
    #1;
    check("rst_clr_n", mem_clr_n, 1'b0);
    check("rst_wr", mem_wr, 1'b0);
    check("rst_rd", mem_rd, 1'b0);
    check("rst_ready", pix_in_ready, 1'b0);
    check("rst_wv", win_valid, 1'b0);
    check("rst_wl", win_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_strip", strip_idx, 2'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle_wr_blocked", mem_wr, 1'b0);

    // Frame A: source always valid, sink always ready.
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("a_clear_busy", busy, 1'b1);
    check("a_clear_clr_n", mem_clr_n, 1'b0);
    check("a_clear_strip", strip_idx, 2'd0);
    tick();
    check("a_load_clr_n", mem_clr_n, 1'b1);
    check("a_load_ready", pix_in_ready, 1'b1);
    check("a_load_wr", mem_wr, 1'b1);
    cyc = 2;
    wait_done(cyc);
    check("a_done_cycle", cyc, 377);
    check("a_busy_at_done", busy, 1'b1);
    frame_totals("a");

    // Frame B: 50% source valid, 10-cycle sink stall at col 5, start pulsed mid-scan.
    toggle_mode = 1'b1;
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (strip_rd != 5 && cyc < LIMIT) begin
      tick();
      cyc++;
    end
    check("b_reached_col5", strip_rd, 5);
    check("b_writes_before_scan", strip_wr, LOAD_N);
    win_ready = 1'b0;
    stall_rd = 0;
    stall_wv = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      stall_rd += mem_rd ? 1 : 0;
      stall_wv += win_valid ? 1 : 0;
      tick();
    end
    win_ready = 1'b1;
    check("b_stall_rd", stall_rd, 0);
    check("b_stall_wv", stall_wv, 1);
    check("b_stall_col_held", strip_rd, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b_start_ignored_strip", strip_idx, 2'd0);
    cyc = 0;
    wait_done(cyc);
    frame_totals("b");

    // Frame C: async reset partway through the first load, then a clean frame.
    toggle_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (strip_wr < 30 && cyc < LIMIT) begin
      tick();
      cyc++;
    end
    check("c_mid_load", mem_wr, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("c_arst_clr_n", mem_clr_n, 1'b0);
    check("c_arst_ready", pix_in_ready, 1'b0);
    check("c_arst_wr", mem_wr, 1'b0);
    check("c_arst_busy", busy, 1'b0);
    check("c_arst_strip", strip_idx, 2'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    wait_done(cyc);
    check("c_done_cycle", cyc, 377);
    frame_totals("c");

    check("wr_without_valid", e_wr_novalid, 0);
    check("wr_data_passthru", e_data, 0);
    check("wr_rd_overlap", e_overlap, 0);
    check("rd_before_full_load", e_rd_early, 0);
    check("last_placement", e_last, 0);
    check("strip_idx_sequence", e_sidx, 0);
`ifdef STRIP_SCAN_COORD_EN
    check("window_coords", e_coord, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
